// File: rtl/bus_arbiter_if.sv
// Bundle of request/grant and address-phase signals between the four bus
// masters and the shared-bus arbiter/multiplexer.
interface bus_arbiter_if;
  logic        m0_req_,    m1_req_,    m2_req_,    m3_req_;
  logic [29:0] m0_addr,    m1_addr,    m2_addr,    m3_addr;
  logic        m0_as_,     m1_as_,     m2_as_,     m3_as_;
  logic        m0_rw,      m1_rw,      m2_rw,      m3_rw;
  logic [31:0] m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data;
  logic        m0_grnt_,   m1_grnt_,   m2_grnt_,   m3_grnt_;
  logic [29:0] s_addr;
  logic        s_as_;
  logic        s_rw;
  logic [31:0] s_wr_data;

  // Master side: drives requests and address phase, receives grants and
  // observes the shared bus.
  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_,
    output m0_addr, m1_addr, m2_addr, m3_addr,
    output m0_as_, m1_as_, m2_as_, m3_as_,
    output m0_rw, m1_rw, m2_rw, m3_rw,
    output m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
    input  s_addr, s_as_, s_rw, s_wr_data
  );

  // Arbiter side: consumes requests and address phase, drives grants and
  // the shared bus.
  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_,
    input  m0_addr, m1_addr, m2_addr, m3_addr,
    input  m0_as_, m1_as_, m2_as_, m3_as_,
    input  m0_rw, m1_rw, m2_rw, m3_rw,
    input  m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
    output s_addr, s_as_, s_rw, s_wr_data
  );
endinterface

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with grant parking on the last owner,
// plus the owner-selected address-phase multiplexer onto the shared bus.
module bus_arbiter (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    OWN_M0 = 2'd0,
    OWN_M1 = 2'd1,
    OWN_M2 = 2'd2,
    OWN_M3 = 2'd3
  } owner_t;

  owner_t      r_owner;
  logic [3:0]  r_grnt_;

  owner_t      w_owner_next;
  logic [3:0]  w_grnt_next_;
  logic [3:0]  w_req;
  logic [1:0]  w_cand;
  logic        w_found;

  assign w_req = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};

  // Next owner: hold while the owner requests or nobody else does; otherwise
  // take the first requester after the owner in rotating order.
  always_comb begin
    w_owner_next = r_owner;
    w_cand       = '0;
    w_found      = 1'b0;
    if (!w_req[r_owner]) begin
      for (int unsigned i = 1; i < 4; i++) begin
        w_cand = r_owner + 2'(i);
        if (!w_found && w_req[w_cand]) begin
          w_found      = 1'b1;
          w_owner_next = owner_t'(w_cand);
        end
      end
    end
  end

  // Active-low one-hot decode of the next owner, registered below.
  always_comb begin
    w_grnt_next_ = '1;
    case (w_owner_next)
      OWN_M0:  w_grnt_next_ = 4'b1110;
      OWN_M1:  w_grnt_next_ = 4'b1101;
      OWN_M2:  w_grnt_next_ = 4'b1011;
      default: w_grnt_next_ = 4'b0111;
    endcase
  end

  // Ownership state and registered grants; reset parks the bus on m0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= OWN_M0;
      r_grnt_ <= 4'b1110;
    end else begin
      r_owner <= w_owner_next;
      r_grnt_ <= w_grnt_next_;
    end
  end

  assign bus.m0_grnt_ = r_grnt_[0];
  assign bus.m1_grnt_ = r_grnt_[1];
  assign bus.m2_grnt_ = r_grnt_[2];
  assign bus.m3_grnt_ = r_grnt_[3];

  // Route the owner's address phase onto the shared bus; non-owners are ignored.
  always_comb begin
    bus.s_addr    = bus.m0_addr;
    bus.s_as_     = bus.m0_as_;
    bus.s_rw      = bus.m0_rw;
    bus.s_wr_data = bus.m0_wr_data;
    case (r_owner)
      OWN_M1: begin
        bus.s_addr    = bus.m1_addr;
        bus.s_as_     = bus.m1_as_;
        bus.s_rw      = bus.m1_rw;
        bus.s_wr_data = bus.m1_wr_data;
      end
      OWN_M2: begin
        bus.s_addr    = bus.m2_addr;
        bus.s_as_     = bus.m2_as_;
        bus.s_rw      = bus.m2_rw;
        bus.s_wr_data = bus.m2_wr_data;
      end
      OWN_M3: begin
        bus.s_addr    = bus.m3_addr;
        bus.s_as_     = bus.m3_as_;
        bus.s_rw      = bus.m3_rw;
        bus.s_wr_data = bus.m3_wr_data;
      end
      default: ;
    endcase
  end

endmodule
